// File: rtl/read_module.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | read_module: reads BRAM words from a base address and streams their bytes |
// | MSB-first as pixels over a valid/ready handshake.            Revision 1.0  |
// +----------------------------------------------------------------------------+
module read_module #(
   parameter int                  DATA_WIDTH     = 32,
   parameter int                  ADDR_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] INPUT_ADDR   = 32'hB000_0000,
   parameter int                  PIXEL_SIZE     = 8,
   parameter int                  PIXEL_PER_WORD = 4,
   parameter int                  COUNT_WIDTH    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] num_words,
   output logic [ADDR_WIDTH-1:0]  bram_addr,
   output logic                   bram_en,
   input  logic [DATA_WIDTH-1:0]  bram_rdata,
   output logic [PIXEL_SIZE-1:0]  pixel,
   output logic                   pixel_valid,
   input  logic                   pixel_ready,
   output logic                   busy,
   output logic                   done
);

   localparam int IDX_W = (PIXEL_PER_WORD > 1) ? $clog2(PIXEL_PER_WORD) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(PIXEL_PER_WORD - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_READ = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_EMIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]             r_state;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [DATA_WIDTH-1:0]  r_word;
   logic [IDX_W-1:0]       r_idx;
   logic [COUNT_WIDTH-1:0] r_words_left;
   logic [PIXEL_SIZE-1:0]  w_pix [PIXEL_PER_WORD];

   genvar gi;
   generate
      for (gi = 0; gi < PIXEL_PER_WORD; gi++) begin : g_unpack
         assign w_pix[gi] = r_word[gi*PIXEL_SIZE +: PIXEL_SIZE];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_addr       <= INPUT_ADDR;
         r_word       <= '0;
         r_idx        <= '0;
         r_words_left <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_addr <= INPUT_ADDR;
               if (start) begin
                  if (num_words != '0) begin
                     r_words_left <= num_words;
                     r_state      <= S_READ;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_READ: r_state <= S_WAIT;
            S_WAIT: begin
               r_word  <= bram_rdata;
               r_idx   <= C_LAST_IDX;
               r_state <= S_EMIT;
            end
            S_EMIT: begin
               // idx only moves on a completed handshake, so a stalled pixel stays put
               if (pixel_ready) begin
                  if (r_idx != '0) begin
                     r_idx <= r_idx - IDX_W'(1);
                  end else if (r_words_left == COUNT_WIDTH'(1)) begin
                     r_state <= S_DONE;
                  end else begin
                     r_words_left <= r_words_left - COUNT_WIDTH'(1);
                     r_addr       <= r_addr + ADDR_WIDTH'(4);
                     r_state      <= S_READ;
                  end
               end
            end
            S_DONE: begin
               r_addr  <= INPUT_ADDR;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bram_addr   = r_addr;
   assign bram_en     = (r_state == S_READ);
   assign pixel_valid = (r_state == S_EMIT);
   assign pixel       = (r_state == S_EMIT) ? w_pix[r_idx] : '0;
   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_read_module.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_read_module: scoreboard bench for read_module with a BRAM model.        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_read_module;

   localparam logic [31:0] BASE = 32'hB000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] num_words = '0;
   logic [31:0] bram_addr;
   logic        bram_en;
   logic [31:0] bram_rdata = '0;
   logic [7:0]  pixel;
   logic        pixel_valid;
   logic        pixel_ready = 1'b1;
   logic        busy;
   logic        done;

   read_module dut (
      .clk(clk), .reset(reset), .start(start), .num_words(num_words),
      .bram_addr(bram_addr), .bram_en(bram_en), .bram_rdata(bram_rdata),
      .pixel(pixel), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [logic [31:0]];
   always @(posedge clk) begin
      if (bram_en) bram_rdata <= mem.exists(bram_addr) ? mem[bram_addr] : 32'h0;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0]  exp_pix [$];
   logic [31:0] exp_addr [$];
   int en_log [$];
   int done_log [$];
   int acc_log [$];
   int pv_count = 0;
   bit busy_at [int];
   bit manual_rdy = 1'b0;
   bit rand_rdy = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void flag(input string name, input logic [31:0] act);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %h with nothing expected", name, act);
   endfunction

   // Monitor: pops the scoreboard whenever the DUT issues a read or a pixel handshake
   initial begin
      logic [7:0] prev_pix = '0;
      bit stalled = 1'b0;
      forever begin
         @(negedge clk);
         busy_at[cyc] = busy;
         if (bram_en) begin
            en_log.push_back(cyc);
            if (exp_addr.size() == 0) flag("unexpected bram_en", bram_addr);
            else chk("bram_addr", bram_addr, exp_addr.pop_front());
         end
         if (done) done_log.push_back(cyc);
         if (pixel_valid) begin
            pv_count++;
            if (stalled) chk("pixel stable under stall", {24'h0, pixel}, {24'h0, prev_pix});
            if (pixel_ready) begin
               acc_log.push_back(cyc);
               if (exp_pix.size() == 0) flag("unexpected pixel", {24'h0, pixel});
               else chk("pixel", {24'h0, pixel}, {24'h0, exp_pix.pop_front()});
            end
         end
         stalled  = pixel_valid && !pixel_ready;
         prev_pix = pixel;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!manual_rdy) pixel_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   task automatic clear_logs();
      en_log.delete();
      done_log.delete();
      acc_log.delete();
   endtask

   // Reference model: word i lives at BASE+4i, bytes leave most significant first
   task automatic load(input logic [31:0] words [$]);
      logic [31:0] w;
      for (int i = 0; i < words.size(); i++) begin
         w = words[i];
         mem[BASE + 32'(4 * i)] = w;
         exp_addr.push_back(BASE + 32'(4 * i));
         for (int b = 3; b >= 0; b--) exp_pix.push_back(w[8*b +: 8]);
      end
   endtask

   task automatic pulse_start(input logic [15:0] n, output int t0);
      @(posedge clk); #1;
      start = 1'b1;
      num_words = n;
      @(posedge clk); #1;
      start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (done_log.size() == 0 && k < 400) begin
         @(negedge clk); #1;
         k++;
      end
      if (done_log.size() == 0) flag({name, " done timeout"}, 32'(k));
      repeat (2) begin
         @(negedge clk); #1;
      end
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   initial begin
      int t0;
      int pv0;
      int nd;
      logic [31:0] wq [$];

      repeat (3) @(posedge clk);
      #1;
      chk("reset bram_addr", bram_addr, BASE);
      chk("reset bram_en", 32'(bram_en), 0);
      chk("reset pixel", 32'(pixel), 0);
      chk("reset pixel_valid", 32'(pixel_valid), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      reset = 1'b0;

      // Single word with exact cycle placement
      clear_logs();
      wq = '{32'h1122_3344};
      load(wq);
      pulse_start(16'd1, t0);
      wait_done("single");
      chk("single en count", 32'(en_log.size()), 1);
      if (en_log.size() > 0) chk("single en cycle", 32'(en_log[0] - t0), 0);
      chk("single accept count", 32'(acc_log.size()), 4);
      if (acc_log.size() == 4) begin
         chk("single first pixel cycle", 32'(acc_log[0] - t0), 2);
         chk("single last pixel cycle", 32'(acc_log[3] - t0), 5);
      end
      if (done_log.size() > 0) chk("single done cycle", 32'(done_log[0] - t0), 6);
      chk("single busy during done", 32'(busy_at[t0 + 6]), 1);
      chk("single busy after done", 32'(busy_at[t0 + 7]), 0);
      chk("single pix queue empty", 32'(exp_pix.size()), 0);

      // Three words
      clear_logs();
      wq = '{32'hA0A1_A2A3, 32'hB0B1_B2B3, 32'hC0C1_C2C3};
      load(wq);
      pulse_start(16'd3, t0);
      wait_done("three");
      chk("three en count", 32'(en_log.size()), 3);
      if (en_log.size() == 3) begin
         chk("three en spacing 1", 32'(en_log[1] - en_log[0]), 6);
         chk("three en spacing 2", 32'(en_log[2] - en_log[1]), 6);
      end
      chk("three accept count", 32'(acc_log.size()), 12);
      chk("three done count", 32'(done_log.size()), 1);
      chk("three pix queue empty", 32'(exp_pix.size()), 0);

      // Backpressure pattern 1,0,0,1,0,1,1 from the first valid cycle
      clear_logs();
      manual_rdy = 1'b1;
      wq = '{32'hDEAD_BEEF};
      load(wq);
      pulse_start(16'd1, t0);
      pixel_ready = 1'b0;
      next_cycle();
      begin
         int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
         for (int i = 0; i < 7; i++) begin
            next_cycle();
            pixel_ready = pat[i][0];
         end
      end
      manual_rdy = 1'b0;
      wait_done("backpressure");
      chk("bp accept count", 32'(acc_log.size()), 4);
      if (acc_log.size() == 4) begin
         chk("bp accept DE", 32'(acc_log[0] - t0), 2);
         chk("bp accept AD", 32'(acc_log[1] - t0), 5);
         chk("bp accept BE", 32'(acc_log[2] - t0), 7);
         chk("bp accept EF", 32'(acc_log[3] - t0), 8);
      end
      if (done_log.size() > 0) chk("bp done cycle", 32'(done_log[0] - t0), 9);

      // Zero words
      clear_logs();
      pv0 = pv_count;
      pulse_start(16'd0, t0);
      wait_done("zero");
      chk("zero en count", 32'(en_log.size()), 0);
      chk("zero done count", 32'(done_log.size()), 1);
      if (done_log.size() > 0) chk("zero done cycle", 32'(done_log[0] - t0), 0);
      chk("zero no pixel_valid", 32'(pv_count - pv0), 0);

      // Second start during EMIT must be ignored
      clear_logs();
      wq = '{32'h0102_0304, 32'h0506_0708};
      load(wq);
      pulse_start(16'd2, t0);
      repeat (3) next_cycle();
      start = 1'b1;
      num_words = 16'd5;
      next_cycle();
      start = 1'b0;
      wait_done("restart");
      repeat (20) next_cycle();
      chk("restart accept count", 32'(acc_log.size()), 8);
      chk("restart done count", 32'(done_log.size()), 1);
      chk("restart en count", 32'(en_log.size()), 2);

      // Reset during EMIT of word 2
      clear_logs();
      wq = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
      load(wq);
      pulse_start(16'd3, t0);
      repeat (9) next_cycle();
      reset = 1'b1;
      next_cycle();
      exp_pix.delete();
      exp_addr.delete();
      chk("midreset bram_addr", bram_addr, BASE);
      chk("midreset bram_en", 32'(bram_en), 0);
      chk("midreset pixel", 32'(pixel), 0);
      chk("midreset pixel_valid", 32'(pixel_valid), 0);
      chk("midreset busy", 32'(busy), 0);
      chk("midreset done", 32'(done), 0);
      reset = 1'b0;
      pv0 = pv_count;
      nd = done_log.size();
      repeat (10) next_cycle();
      chk("midreset no pixel after", 32'(pv_count - pv0), 0);
      chk("midreset no done after", 32'(done_log.size() - nd), 0);
      clear_logs();
      wq = '{32'h5A6B_7C8D};
      load(wq);
      pulse_start(16'd1, t0);
      wait_done("post-reset");
      chk("post-reset en count", 32'(en_log.size()), 1);
      chk("post-reset accept count", 32'(acc_log.size()), 4);

      // Random transfers with random backpressure
      rand_rdy = 1'b1;
      for (int t = 0; t < 10; t++) begin
         int n;
         n = $urandom_range(0, 4);
         clear_logs();
         wq.delete();
         for (int i = 0; i < n; i++) wq.push_back($urandom);
         load(wq);
         pulse_start(16'(n), t0);
         wait_done("random");
         chk("random accept count", 32'(acc_log.size()), 32'(4 * n));
         chk("random en count", 32'(en_log.size()), 32'(n));
         chk("random pix queue empty", 32'(exp_pix.size()), 0);
      end
      rand_rdy = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
